// File: rtl/dac_stepper_pkg.sv
// Shared definitions for the DAC code stepper: FSM state encodings,
// channel identifiers and the default code width.
package dac_stepper_pkg;

    localparam int DEFAULT_CODE_WIDTH = 10;

    // Channel select values as seen on dac_ch.
    localparam logic CH_A = 1'b0;
    localparam logic CH_B = 1'b1;

    // Request FSM state encodings.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_REQ  = 2'd1;
    localparam state_t ST_GAP  = 2'd2;

endpackage

// File: rtl/dac_code_stepper_key_event.sv
// Per-key event generator: history register, press-edge detect and,
// when DAC_STEPPER_AUTO_REPEAT_EN is defined, a hold-to-repeat counter.
// Emits a one-cycle pulse per press (or repeat) event.
module key_event #(
    parameter logic        C_KEY_ACTIVE    = 1'b0,
    parameter bit          C_REPEAT_EN     = 1'b1,
    parameter int unsigned C_REPEAT_DELAY  = 50_000_000,
    parameter int unsigned C_REPEAT_PERIOD = 5_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic event_out
);

    logic pressed;
    logic press_ev;
    logic hist_q;
    logic hist_d;

    assign pressed  = (key_in == C_KEY_ACTIVE);
    assign press_ev = pressed & ~hist_q;

    // Next history value: the key's pressed state this cycle.
    always_comb begin
        hist_d = pressed;
    end

    // History starts inactive so a key held through reset yields one press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= 1'b0;
        end else begin
            hist_q <= hist_d;
        end
    end

`ifdef DAC_STEPPER_AUTO_REPEAT_EN
    // cnt_q counts cycles since the last press/repeat event; rep_q selects
    // whether the initial delay or the repeat period is being timed.
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;
    logic        rep_q;
    logic        rep_d;
    logic        repeat_ev;

    // Repeat timing: restart on press, fire on reaching the active limit.
    always_comb begin
        cnt_d     = cnt_q;
        rep_d     = rep_q;
        repeat_ev = 1'b0;
        if (!C_REPEAT_EN || !pressed) begin
            cnt_d = 32'd0;
            rep_d = 1'b0;
        end else if (press_ev) begin
            cnt_d = 32'd1;
            rep_d = 1'b0;
        end else if (cnt_q == (rep_q ? C_REPEAT_PERIOD : C_REPEAT_DELAY)) begin
            repeat_ev = 1'b1;
            cnt_d     = 32'd1;
            rep_d     = 1'b1;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // Repeat counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 32'd0;
            rep_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            rep_q <= rep_d;
        end
    end

    assign event_out = press_ev | repeat_ev;
`else
    assign event_out = press_ev;
`endif

endmodule

// File: rtl/dac_code_stepper.sv
// Front-panel key to AD5313R code-update request converter.
// Keeps a saturating code per channel and issues updates over a req/ack
// handshake; changes made during a transfer coalesce into one follow-up.
// Optional build macro: DAC_STEPPER_AUTO_REPEAT_EN (hold-to-repeat).
module dac_code_stepper
    import dac_stepper_pkg::*;
#(
    parameter int          C_CODE_WIDTH    = DEFAULT_CODE_WIDTH,
    parameter int          C_STEP          = 1,
    parameter logic        C_KEY_ACTIVE    = 1'b0,
    parameter int          C_INIT_CODE     = 0,
    parameter int unsigned C_REPEAT_DELAY  = 50_000_000,
    parameter int unsigned C_REPEAT_PERIOD = 5_000_000
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic                    key_up_in,
    input  logic                    key_down_in,
    input  logic                    key_ch_in,
    input  logic                    dac_ack,
    output logic                    dac_req,
    output logic                    dac_ch,
    output logic [C_CODE_WIDTH-1:0] dac_code
);

    localparam logic [C_CODE_WIDTH-1:0] STEP = C_CODE_WIDTH'(C_STEP);
    localparam logic [C_CODE_WIDTH-1:0] INIT = C_CODE_WIDTH'(C_INIT_CODE);

    // Add the step in W+1 bits and clamp to full scale on carry-out.
    function automatic logic [C_CODE_WIDTH-1:0] sat_add(input logic [C_CODE_WIDTH-1:0] c);
        logic [C_CODE_WIDTH:0] sum;
        sum = {1'b0, c} + {1'b0, STEP};
        if (sum[C_CODE_WIDTH]) begin
            sat_add = '1;
        end else begin
            sat_add = sum[C_CODE_WIDTH-1:0];
        end
    endfunction

    // Subtract the step, clamping at zero instead of wrapping.
    function automatic logic [C_CODE_WIDTH-1:0] sat_sub(input logic [C_CODE_WIDTH-1:0] c);
        if (c < STEP) begin
            sat_sub = '0;
        end else begin
            sat_sub = c - STEP;
        end
    endfunction

    logic up_ev;
    logic dn_ev;
    logic ch_ev;

    key_event #(
        .C_KEY_ACTIVE    (C_KEY_ACTIVE),
        .C_REPEAT_EN     (1'b1),
        .C_REPEAT_DELAY  (C_REPEAT_DELAY),
        .C_REPEAT_PERIOD (C_REPEAT_PERIOD)
    ) u_key_up (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .key_in    (key_up_in),
        .event_out (up_ev)
    );

    key_event #(
        .C_KEY_ACTIVE    (C_KEY_ACTIVE),
        .C_REPEAT_EN     (1'b1),
        .C_REPEAT_DELAY  (C_REPEAT_DELAY),
        .C_REPEAT_PERIOD (C_REPEAT_PERIOD)
    ) u_key_down (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .key_in    (key_down_in),
        .event_out (dn_ev)
    );

    // The channel key never auto-repeats.
    key_event #(
        .C_KEY_ACTIVE    (C_KEY_ACTIVE),
        .C_REPEAT_EN     (1'b0),
        .C_REPEAT_DELAY  (C_REPEAT_DELAY),
        .C_REPEAT_PERIOD (C_REPEAT_PERIOD)
    ) u_key_ch (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .key_in    (key_ch_in),
        .event_out (ch_ev)
    );

    state_t                  state_q, state_d;
    logic                    pend_q, pend_d;
    logic                    sel_q, sel_d;
    logic [C_CODE_WIDTH-1:0] code_a_q, code_a_d;
    logic [C_CODE_WIDTH-1:0] code_b_q, code_b_d;
    logic                    req_q, req_d;
    logic                    ch_q, ch_d;
    logic [C_CODE_WIDTH-1:0] code_out_q, code_out_d;

    logic [C_CODE_WIDTH-1:0] cur_code;
    logic [C_CODE_WIDTH-1:0] new_code;
    logic                    changed;

    // Apply up/down events to the selected channel's code with saturation.
    // Events always act on the channel selected before this cycle's toggle.
    always_comb begin
        cur_code = (sel_q == CH_B) ? code_b_q : code_a_q;
        new_code = cur_code;
        if (up_ev && !dn_ev) begin
            new_code = sat_add(cur_code);
        end else if (dn_ev && !up_ev) begin
            new_code = sat_sub(cur_code);
        end
        changed  = (new_code != cur_code);
        code_a_d = code_a_q;
        code_b_d = code_b_q;
        if (sel_q == CH_B) begin
            code_b_d = new_code;
        end else begin
            code_a_d = new_code;
        end
        sel_d = sel_q;
        if (ch_ev && (state_q == ST_IDLE) && !pend_q) begin
            sel_d = ~sel_q;
        end
    end

    // Request FSM: issue, wait for ack, one gap cycle, optional follow-up.
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        req_d      = req_q;
        ch_d       = ch_q;
        code_out_d = code_out_q;
        case (state_q)
            ST_IDLE: begin
                if (changed) begin
                    state_d    = ST_REQ;
                    req_d      = 1'b1;
                    ch_d       = sel_q;
                    code_out_d = new_code;
                end
            end
            ST_REQ: begin
                if (changed) begin
                    pend_d = 1'b1;
                end
                if (dac_ack) begin
                    state_d = ST_GAP;
                    req_d   = 1'b0;
                end
            end
            ST_GAP: begin
                // A change landing in the gap cycle itself is folded into
                // the follow-up so the latest code is always what goes out.
                if (pend_q || changed) begin
                    state_d    = ST_REQ;
                    pend_d     = 1'b0;
                    req_d      = 1'b1;
                    ch_d       = sel_q;
                    code_out_d = new_code;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pend_d  = 1'b0;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any transfer in flight.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            pend_q     <= 1'b0;
            sel_q      <= CH_A;
            code_a_q   <= INIT;
            code_b_q   <= INIT;
            req_q      <= 1'b0;
            ch_q       <= CH_A;
            code_out_q <= INIT;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            sel_q      <= sel_d;
            code_a_q   <= code_a_d;
            code_b_q   <= code_b_d;
            req_q      <= req_d;
            ch_q       <= ch_d;
            code_out_q <= code_out_d;
        end
    end

    assign dac_req  = req_q;
    assign dac_ch   = ch_q;
    assign dac_code = code_out_q;

endmodule

// File: tb/tb_dac_code_stepper.sv
// Self-checking bench for dac_code_stepper: a cycle-accurate vector table
// plus directed sequences for toggling, saturation, reset and auto-repeat.
module tb_dac_code_stepper;

    logic       clk;
    logic       rst_n;
    logic       key_up, key_dn, key_ch, ack;
    logic       dac_req, dac_ch;
    logic [9:0] dac_code;

    logic       s_up, s_dn, s_ch, s_ack;
    logic       s_req, s_chan;
    logic [9:0] s_code;

    int errors = 0;
    int checks = 0;

    dac_code_stepper #(
        .C_CODE_WIDTH    (10),
        .C_STEP          (1),
        .C_KEY_ACTIVE    (1'b0),
        .C_INIT_CODE     (0),
        .C_REPEAT_DELAY  (10),
        .C_REPEAT_PERIOD (4)
    ) dut (
        .sys_clk     (clk),
        .sys_rst_n   (rst_n),
        .key_up_in   (key_up),
        .key_down_in (key_dn),
        .key_ch_in   (key_ch),
        .dac_ack     (ack),
        .dac_req     (dac_req),
        .dac_ch      (dac_ch),
        .dac_code    (dac_code)
    );

    dac_code_stepper #(
        .C_CODE_WIDTH    (10),
        .C_STEP          (4),
        .C_KEY_ACTIVE    (1'b0),
        .C_INIT_CODE     (1022),
        .C_REPEAT_DELAY  (10),
        .C_REPEAT_PERIOD (4)
    ) dut_sat (
        .sys_clk     (clk),
        .sys_rst_n   (rst_n),
        .key_up_in   (s_up),
        .key_down_in (s_dn),
        .key_ch_in   (s_ch),
        .dac_ack     (s_ack),
        .dac_req     (s_req),
        .dac_ch      (s_chan),
        .dac_code    (s_code)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic       up;
        logic       dn;
        logic       ch;
        logic       ack;
        logic       exp_req;
        logic       exp_ch;
        logic [9:0] exp_code;
    } vec_t;

    vec_t vecs[24];

    // Keys are active-low: a 1 in the pressed arguments drives the pin low.
    task automatic drive(input logic up, input logic dn, input logic ch, input logic a);
        key_up = ~up;
        key_dn = ~dn;
        key_ch = ~ch;
        ack    = a;
    endtask

    task automatic check(input string name, input logic e_req, input logic e_ch, input logic [9:0] e_code);
        checks++;
        if (dac_req !== e_req || dac_ch !== e_ch || dac_code !== e_code) begin
            errors++;
            $display("FAIL %s: got req=%0b ch=%0b code=%0d, want req=%0b ch=%0b code=%0d",
                     name, dac_req, dac_ch, dac_code, e_req, e_ch, e_code);
        end
    endtask

    task automatic check_sat(input string name, input logic e_req, input logic e_ch, input logic [9:0] e_code);
        checks++;
        if (s_req !== e_req || s_chan !== e_ch || s_code !== e_code) begin
            errors++;
            $display("FAIL %s: got req=%0b ch=%0b code=%0d, want req=%0b ch=%0b code=%0d",
                     name, s_req, s_chan, s_code, e_req, e_ch, e_code);
        end
    endtask

    // One key press with a one-cycle ack, returning to IDLE afterwards.
    task automatic step_key(input logic up, input logic dn, input logic e_ch,
                            input logic [9:0] e_code, input string name);
        drive(up, dn, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check({name, "_req"}, 1'b1, e_ch, e_code);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check({name, "_gap"}, 1'b0, e_ch, e_code);
        @(negedge clk);
    endtask

    task automatic toggle(input logic e_ch, input logic [9:0] e_code, input string name);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check(name, 1'b0, e_ch, e_code);
    endtask

    logic       prev_req;
    logic [9:0] got_code[$];
    int         got_edge[$];
    logic [9:0] exp_rcode[$];
    int         exp_redge[$];

    initial begin
        // up dn ch ack | req ch code   (expected after the following edge)
        vecs[0]  = '{0, 0, 0, 0, 0, 0, 10'd0};  // idle
        vecs[1]  = '{0, 1, 0, 0, 0, 0, 10'd0};  // down at zero: no request
        vecs[2]  = '{0, 0, 0, 0, 0, 0, 10'd0};
        vecs[3]  = '{1, 0, 0, 0, 1, 0, 10'd1};  // up press: 1-cycle latency
        vecs[4]  = '{1, 0, 0, 0, 1, 0, 10'd1};  // held: no second event
        vecs[5]  = '{0, 0, 0, 1, 0, 0, 10'd1};  // ack drops req
        vecs[6]  = '{0, 0, 0, 0, 0, 0, 10'd1};  // gap -> idle
        vecs[7]  = '{1, 0, 0, 0, 1, 0, 10'd2};  // new request
        vecs[8]  = '{0, 0, 0, 0, 1, 0, 10'd2};
        vecs[9]  = '{1, 0, 0, 0, 1, 0, 10'd2};  // code 3, pending, output held
        vecs[10] = '{0, 0, 0, 0, 1, 0, 10'd2};
        vecs[11] = '{1, 0, 0, 0, 1, 0, 10'd2};  // code 4, still one pending
        vecs[12] = '{0, 0, 0, 1, 0, 0, 10'd2};  // ack -> gap
        vecs[13] = '{0, 0, 0, 0, 1, 0, 10'd4};  // follow-up with latest code
        vecs[14] = '{0, 0, 0, 1, 0, 0, 10'd4};
        vecs[15] = '{0, 0, 0, 0, 0, 0, 10'd4};
        vecs[16] = '{0, 0, 0, 0, 0, 0, 10'd4};  // only one follow-up
        vecs[17] = '{1, 1, 0, 0, 0, 0, 10'd4};  // simultaneous up+down discarded
        vecs[18] = '{0, 0, 0, 0, 0, 0, 10'd4};
        vecs[19] = '{0, 0, 0, 1, 0, 0, 10'd4};  // ack in idle ignored
        vecs[20] = '{0, 0, 0, 0, 0, 0, 10'd4};
        vecs[21] = '{0, 1, 0, 0, 1, 0, 10'd3};  // down press
        vecs[22] = '{0, 0, 0, 1, 0, 0, 10'd3};
        vecs[23] = '{0, 0, 0, 0, 0, 0, 10'd3};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        s_up = 1'b1; s_dn = 1'b1; s_ch = 1'b1; s_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_state", 1'b0, 1'b0, 10'd0);
        check_sat("reset_state_sat", 1'b0, 1'b0, 10'd1022);
        rst_n = 1'b1;
        @(negedge clk);

        // Upper saturation: 1022 + 4 clamps to 1023, then no further request.
        s_up = 1'b0;
        @(negedge clk);
        s_up = 1'b1;
        check_sat("sat_first", 1'b1, 1'b0, 10'd1023);
        s_ack = 1'b1;
        @(negedge clk);
        s_ack = 1'b0;
        check_sat("sat_first_gap", 1'b0, 1'b0, 10'd1023);
        @(negedge clk);
        s_up = 1'b0;
        @(negedge clk);
        s_up = 1'b1;
        check_sat("sat_second", 1'b0, 1'b0, 10'd1023);
        @(negedge clk);
        check_sat("sat_second_idle", 1'b0, 1'b0, 10'd1023);

        for (int i = 0; i < 24; i++) begin
            drive(vecs[i].up, vecs[i].dn, vecs[i].ch, vecs[i].ack);
            @(negedge clk);
            check($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_ch, vecs[i].exp_code);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        // Channel toggle: B counts up to 5, then down to 4; A is untouched.
        toggle(1'b0, 10'd3, "tog_idle");
        for (int i = 1; i <= 5; i++) begin
            step_key(1'b1, 1'b0, 1'b1, 10'(i), $sformatf("b_up%0d", i));
        end
        step_key(1'b0, 1'b1, 1'b1, 10'd4, "b_down");
        toggle(1'b1, 10'd4, "tog_back");
        step_key(1'b1, 1'b0, 1'b0, 10'd4, "code_a_kept");

        // Toggle during REQ is dropped.
        toggle(1'b0, 10'd4, "tog_to_b");
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("req_b", 1'b1, 1'b1, 10'd5);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("tog_in_req", 1'b1, 1'b1, 10'd5);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("tog_in_req_gap", 1'b0, 1'b1, 10'd5);
        @(negedge clk);
        step_key(1'b1, 1'b0, 1'b1, 10'd6, "tog_dropped");

        // Asynchronous reset mid-transfer, with up held through release.
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("pre_reset_req", 1'b1, 1'b1, 10'd7);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 1'b0, 1'b0, 10'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check("held_through_reset", 1'b1, 1'b0, 10'd1);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("held_through_reset_gap", 1'b0, 1'b0, 10'd1);
        @(negedge clk);
        @(negedge clk);
        check("no_stale_pending", 1'b0, 1'b0, 10'd1);

        // Auto-repeat: hold up from code 0 with immediate ack.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
`ifdef DAC_STEPPER_AUTO_REPEAT_EN
        exp_redge = '{0, 10, 14, 18, 22};
        exp_rcode = '{10'd1, 10'd2, 10'd3, 10'd4, 10'd5};
`else
        exp_redge = '{0};
        exp_rcode = '{10'd1};
`endif
        prev_req = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (dac_req && !prev_req) begin
                got_code.push_back(dac_code);
                got_edge.push_back(k);
            end
            prev_req = dac_req;
            drive(k < 22, 1'b0, 1'b0, dac_req);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (got_code.size() != exp_rcode.size()) begin
            errors++;
            $display("FAIL rep_count: got %0d requests, want %0d", got_code.size(), exp_rcode.size());
        end
        for (int i = 0; i < exp_rcode.size(); i++) begin
            checks++;
            if (i >= got_code.size()) begin
                errors++;
                $display("FAIL rep%0d: missing request, want code=%0d at edge %0d", i, exp_rcode[i], exp_redge[i]);
            end else if (got_code[i] !== exp_rcode[i] || got_edge[i] != exp_redge[i]) begin
                errors++;
                $display("FAIL rep%0d: got code=%0d at edge %0d, want code=%0d at edge %0d",
                         i, got_code[i], got_edge[i], exp_rcode[i], exp_redge[i]);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
